enemy_spawner: RTL and testbench
================================

// Module: enemy_spawner
// PURPOSE
// - Upstream control stage for the enemy car sprite. Drives its offset_x, offset_y and reset inputs.
// - Picks a pseudo-random lane for each new enemy and holds the sprite in reset long enough for
//   the sprite's slow motion clock to sample it. Releases the car, then watches the returned
//   pos_y to detect when the car leaves the screen.
// - Reacts to player collisions and counts dodged cars.
// PARAMETERS
// - NUM_LANES   4        lanes, 1..8
// - LANE_X0     160      x of lane 0 left edge, in px
// - LANE_PITCH  80       px between lanes; LANE_X0+(NUM_LANES-1)*LANE_PITCH <= 560
// - START_Y     0        offset_y driven to the sprite
// - EXIT_Y      480      pos_y >= EXIT_Y means the car has left the screen
// - RESET_HOLD  2600000  cycles enemy_reset is held after a pick; must exceed one motion-clock period (2500000)
// - GAP_CYCLES  5000000  cycles between an exit and the next pick
// PORTS
// - clk          in   1   system pixel clock
// - reset        in   1   asynchronous, active-low
// - run          in   1   game running (level)
// - collision    in   1   single-cycle pulse, player hit the enemy
// - enemy_pos_y  in   10  pos_y returned by the enemy sprite
// - offset_x     out  10  lane x to the sprite
// - offset_y     out  10  constant START_Y
// - enemy_reset  out  1   reset to the sprite, active-high
// - active       out  1   enemy moving (RUN state)
// - lane         out  3   current lane index
// - dodged       out  8   enemies that exited (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, reset=0):
//   - state=IDLE, lfsr=16'hACE1, prev lane=0, lane=0, offset_x=LANE_X0
//   - enemy_reset=1, active=0, dodged=0, hold/gap counter=0
// - LFSR:
//   - 16-bit Galois, taps 16,14,13,11; advances every cycle in every state; never all-zero.
// - All outputs are registered; a state's outputs are valid the cycle after entering it.
// - States:
//   - IDLE: enemy_reset=1, active=0. run=1 -> PICK.
//   - PICK: one cycle.
//     - cand = lfsr[2:0] % NUM_LANES; if cand==prev lane and NUM_LANES>1, cand=(cand+1)%NUM_LANES.
//     - lane<=cand; offset_x<=LANE_X0+cand*LANE_PITCH (10-bit); counter<=0 -> HOLD.
//   - HOLD: enemy_reset=1; counter++. Counter==RESET_HOLD-1 -> RUN, counter<=0.
//   - RUN: enemy_reset=0, active=1.
//     - collision=1 -> HALT.
//     - else enemy_pos_y>=EXIT_Y -> GAP, dodged++.
//   - GAP: enemy_reset=1, active=0; counter++. Counter==GAP_CYCLES-1 -> PICK, prev lane<=lane.
//   - HALT: enemy_reset=0 (car stays visible, frozen only by the sprite's own limit); active=0.
//     run=0 -> IDLE.
// - Priority, each cycle:
//   - run=0 in any state except HALT -> IDLE next cycle (overrides every other transition).
//   - In RUN, collision wins over a same-cycle exit; dodged does not increment.
//   - collision outside RUN is ignored.
// - offset_x only changes in PICK; it is stable while enemy_reset=0.
// - Reset asserted mid-HOLD/RUN/GAP: immediate IDLE and enemy_reset=1; dodged clears.
// - Counters are wide enough for max(RESET_HOLD,GAP_CYCLES) (>=23 bits); no wrap within a state.
// CONFIGURATION
// - SPAWNER_SCORE_EN defined:
//   - dodged is an 8-bit saturating counter: it holds at 255 and never wraps.
//   - It clears only on reset or on the IDLE->PICK transition (new game).
// - SPAWNER_SCORE_EN undefined:
//   - dodged is tied to 8'd0; no counter logic is synthesized.
//   - FSM behaviour is otherwise identical.
// TESTING (bench overrides RESET_HOLD=8, GAP_CYCLES=4, NUM_LANES=4)
// - Release reset with run=0 for 20 cycles -> state IDLE, enemy_reset=1, active=0, offset_y=0.
// - run=1 -> PICK one cycle, then enemy_reset=1 for exactly 8 cycles, then active=1, enemy_reset=0.
//   offset_x is in {160,240,320,400}.
// - In RUN drive enemy_pos_y=479 then 480 -> GAP on the 480 cycle.
//   - dodged=1.
//   - 4 cycles later PICK; new lane != previous lane (check over 50 spawns).
// - In RUN, pulse collision in the same cycle as enemy_pos_y=480 -> HALT, dodged unchanged,
//   enemy_reset=0. Then run=0 -> IDLE.
// - Assert reset mid-HOLD, counter=5 -> enemy_reset=1 and state IDLE within the same cycle; dodged=0.
// - With SPAWNER_SCORE_EN: 260 exits -> dodged=255. Without it: dodged=0 throughout.

Source files
------------

// File: rtl/enemy_spawner.sv
// Enemy car spawner: picks a pseudo-random lane, holds the sprite in reset, releases it and
// tracks exit/collision. Define SPAWNER_SCORE_EN to enable the saturating dodged counter.
module enemy_spawner #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LANE_X0    = 160,
  parameter int unsigned LANE_PITCH = 80,
  parameter int unsigned START_Y    = 0,
  parameter int unsigned EXIT_Y     = 480,
  parameter int unsigned RESET_HOLD = 2600000,
  parameter int unsigned GAP_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       collision,
  input  logic [9:0] enemy_pos_y,
  output logic [9:0] offset_x,
  output logic [9:0] offset_y,
  output logic       enemy_reset,
  output logic       active,
  output logic [2:0] lane,
  output logic [7:0] dodged
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned LANE_W  = 3;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned CNT_MAX = (RESET_HOLD > GAP_CYCLES) ? RESET_HOLD : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_HOLD,
    S_RUN,
    S_GAP,
    S_HALT
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [LANE_W-1:0]   prev_lane, prev_lane_nxt;
  logic [LANE_W-1:0]   lane_nxt;
  logic [LANE_W-1:0]   cand_raw, cand;
  logic [POS_W-1:0]    offset_x_nxt;
  logic                enemy_reset_nxt;
  logic                active_nxt;
  logic                score_inc;
  logic                score_clr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lane candidate: avoid repeating the previous lane when there is a choice
  always_comb begin
    cand_raw = LANE_W'(32'(lfsr[2:0]) % NUM_LANES);
    cand     = cand_raw;
    if ((NUM_LANES > 1) && (cand_raw == prev_lane)) begin
      cand = LANE_W'((32'(cand_raw) + 32'd1) % NUM_LANES);
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    prev_lane_nxt = prev_lane;
    lane_nxt      = lane;
    offset_x_nxt  = offset_x;
    score_inc     = 1'b0;
    score_clr     = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_PICK;
          score_clr = 1'b1;
        end
      end
      S_PICK: begin
        lane_nxt     = cand;
        offset_x_nxt = POS_W'(LANE_X0 + 32'(cand) * LANE_PITCH);
        cnt_nxt      = '0;
        state_nxt    = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == CNT_W'(RESET_HOLD - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (collision) begin
          state_nxt = S_HALT;
        end else if (enemy_pos_y >= POS_W'(EXIT_Y)) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
          score_inc = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt       = '0;
          prev_lane_nxt = lane;
          state_nxt     = S_PICK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Dropping run abandons the current car from any state except HALT
    if (!run && (state != S_HALT)) begin
      state_nxt     = S_IDLE;
      cnt_nxt       = '0;
      prev_lane_nxt = prev_lane;
      lane_nxt      = lane;
      offset_x_nxt  = offset_x;
      score_inc     = 1'b0;
      score_clr     = 1'b0;
    end

    enemy_reset_nxt = !((state_nxt == S_RUN) || (state_nxt == S_HALT));
    active_nxt      = (state_nxt == S_RUN);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      prev_lane   <= '0;
      lane        <= '0;
      offset_x    <= POS_W'(LANE_X0);
      offset_y    <= POS_W'(START_Y);
      enemy_reset <= 1'b1;
      active      <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      lfsr        <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
      prev_lane   <= prev_lane_nxt;
      lane        <= lane_nxt;
      offset_x    <= offset_x_nxt;
      offset_y    <= POS_W'(START_Y);
      enemy_reset <= enemy_reset_nxt;
      active      <= active_nxt;
    end
  end

`ifdef SPAWNER_SCORE_EN
  logic [SCORE_W-1:0] score;

  // Saturating dodge counter, cleared at the start of each game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score <= '0;
    end else if (score_clr) begin
      score <= '0;
    end else if (score_inc && (score != {SCORE_W{1'b1}})) begin
      score <= score + SCORE_W'(1);
    end
  end

  assign dodged = score;
`else
  logic unused_score;

  assign unused_score = score_inc ^ score_clr;
  assign dodged       = SCORE_W'(0);
`endif

endmodule

// File: tb/tb_enemy_spawner.sv
// Scoreboard bench for enemy_spawner: stimulus queues expected output events, a negedge
// monitor pops one whenever reset/enemy_reset/active/dodged change and compares.
module tb_enemy_spawner;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       collision;
  logic [9:0] enemy_pos_y;
  logic [9:0] offset_x;
  logic [9:0] offset_y;
  logic       enemy_reset;
  logic       active;
  logic [2:0] lane;
  logic [7:0] dodged;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_dod = 8'd0;

  typedef struct {
    string      name;
    int         cyc;
    logic       er;
    logic       act;
    logic [7:0] dod;
    bit         chk_lane;
    bit         distinct;
    bit         chk_rst_pos;
  } exp_t;

  exp_t sb[$];

  enemy_spawner #(
    .NUM_LANES (4),
    .RESET_HOLD(8),
    .GAP_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .collision  (collision),
    .enemy_pos_y(enemy_pos_y),
    .offset_x   (offset_x),
    .offset_y   (offset_y),
    .enemy_reset(enemy_reset),
    .active     (active),
    .lane       (lane),
    .dodged     (dodged)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(string n, int c, logic er, logic act, logic [7:0] d,
                                    bit cl, bit ds, bit cr);
    exp_t e;
    e.name = n; e.cyc = c; e.er = er; e.act = act; e.dod = d;
    e.chk_lane = cl; e.distinct = ds; e.chk_rst_pos = cr;
    sb.push_back(e);
  endfunction

  function automatic void bump_dod();
`ifdef SPAWNER_SCORE_EN
    if (exp_dod != 8'd255) exp_dod = exp_dod + 8'd1;
`endif
  endfunction

  // Monitor: one scoreboard entry per observable output change
  logic [10:0] obs;
  logic [10:0] prev_obs = 'x;
  logic [2:0]  last_lane = '0;
  exp_t        cur;
  bit          ok;

  always @(negedge clk) begin
    obs = {reset, enemy_reset, active, dodged};
    if (obs !== prev_obs) begin
      prev_obs = obs;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d er=%b act=%b dodged=%0d, required no event",
                 cyc, enemy_reset, active, dodged);
      end else begin
        cur = sb.pop_front();
        ok = (enemy_reset === cur.er) && (active === cur.act) && (dodged === cur.dod) &&
             (offset_y === 10'd0) && ((cur.cyc < 0) || (cyc == cur.cyc));
        if (cur.chk_lane) begin
          ok = ok && (lane < 3'd4) && (32'(offset_x) == 160 + 80 * 32'(lane));
          if (cur.distinct) ok = ok && (lane != last_lane);
          last_lane = lane;
        end
        if (cur.chk_rst_pos) ok = ok && (lane === 3'd0) && (offset_x === 10'd160);
        if (!ok) begin
          errors++;
          $display("FAIL %s: cyc=%0d er=%b act=%b dodged=%0d lane=%0d x=%0d y=%0d prev_lane=%0d, required cyc=%0d er=%b act=%b dodged=%0d y=0",
                   cur.name, cyc, enemy_reset, active, dodged, lane, offset_x, offset_y,
                   last_lane, cur.cyc, cur.er, cur.act, cur.dod);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: run goes high, one PICK cycle, eight HOLD cycles, then RUN
  task automatic start_game(bit pulse_col);
    int n;
    n = cyc;
    if (exp_dod != 8'd0) begin
      exp_dod = 8'd0;
      expect_ev("dodged_clear", n + 1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    end
    expect_ev("run_start", n + 10, 1'b0, 1'b1, exp_dod, 1'b1, 1'b0, 1'b0);
    run = 1'b1;
    repeat (4) tick();
    collision = pulse_col;
    tick();
    collision = 1'b0;
    repeat (5) tick();
  endtask

  // From RUN: 479 keeps running, 480 exits, GAP 4 + PICK 1 + HOLD 8 before next RUN
  task automatic exit_car();
    int b;
    enemy_pos_y = 10'd479;
    tick();
    b = cyc;
    bump_dod();
    expect_ev("exit_gap", b + 1, 1'b1, 1'b0, exp_dod, 1'b0, 1'b0, 1'b0);
    enemy_pos_y = 10'd480;
    tick();
    enemy_pos_y = 10'd0;
    expect_ev("respawn_run", b + 14, 1'b0, 1'b1, exp_dod, 1'b1, 1'b1, 1'b0);
    repeat (13) tick();
  endtask

  // From RUN: collision together with an exit halts without scoring
  task automatic collide_halt();
    int b;
    b = cyc;
    expect_ev("halt", b + 1, 1'b0, 1'b0, exp_dod, 1'b0, 1'b0, 1'b0);
    collision = 1'b1;
    enemy_pos_y = 10'd480;
    tick();
    collision = 1'b0;
    enemy_pos_y = 10'd0;
    repeat (3) tick();
    b = cyc;
    expect_ev("halt_to_idle", b + 1, 1'b1, 1'b0, exp_dod, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    tick();
  endtask

  task automatic run_stop();
    int b;
    b = cyc;
    expect_ev("run_drop_idle", b + 1, 1'b1, 1'b0, exp_dod, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    tick();
  endtask

  // From RUN: exit, then assert reset when the HOLD counter reads 5
  task automatic reset_in_hold();
    int b;
    b = cyc;
    bump_dod();
    expect_ev("exit_gap", b + 1, 1'b1, 1'b0, exp_dod, 1'b0, 1'b0, 1'b0);
    enemy_pos_y = 10'd480;
    tick();
    enemy_pos_y = 10'd0;
    repeat (10) tick();
    expect_ev("reset_mid_hold", cyc, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    run = 1'b0;
    exp_dod = 8'd0;
    tick();
    expect_ev("reset_release2", cyc, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t, required finish before 500000", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    run = 1'b0;
    collision = 1'b0;
    enemy_pos_y = 10'd0;
    expect_ev("reset_state", -1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    repeat (3) tick();
    expect_ev("reset_release", cyc, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (20) tick();

    // Collision outside RUN must not produce any output change
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();

    start_game(1'b1);
    repeat (3) exit_car();
    collide_halt();
    repeat (3) tick();

    start_game(1'b0);
    repeat (2) exit_car();
    run_stop();
    repeat (2) tick();

    start_game(1'b0);
    exit_car();
    reset_in_hold();
    repeat (2) tick();

    start_game(1'b0);
    repeat (260) exit_car();
    run_stop();
    repeat (5) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unobserved, required 0 (next %s)",
               sb.size(), sb[0].name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
